// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network event path.
// Holds the default requester count, event address width and event FIFO
// depth, the event address type, and a helper that sizes index fields.
package snn_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int ADDR_W_DEF  = 4;
    localparam int DEPTH_DEF   = 8;

    // Presynaptic event address at the default width.
    typedef logic [ADDR_W_DEF-1:0] evt_addr_t;

    // Width of an index into n items. It is never zero, so a single
    // requester still gets a legal one-bit vector.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for event requesters.
// The search for a requester starts at rr_ptr and wraps modulo NUM_REQ.
// The first index found with its request high wins.
// Ports:
//   enable    - when low, no grant is issued (FIFO full, or reset asserted)
//   req       - per-requester request bits
//   rr_ptr    - index where the search starts
//   gnt       - one-hot grant; all zero when there is no winner
//   gnt_idx   - binary index of the winner
//   gnt_valid - a grant was issued
module rr_arbiter
    import snn_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic               enable,
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               gnt_valid
);

    int idx;

    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        idx       = 0;
        if (enable) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                // rr_ptr is always below NUM_REQ, so one subtraction is enough to wrap.
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!gnt_valid && req[idx]) begin
                    gnt[idx]  = 1'b1;
                    gnt_idx   = IDX_W'(idx);
                    gnt_valid = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/event_scheduler.sv
// Event scheduler: accepts events from NUM_REQ requesters, using round-robin
// arbitration, and queues them in a DEPTH-entry FIFO. The events are then
// dispatched in order to the neuron core.
// Ports:
//   clock, reset   - single clock; asynchronous active-high reset
//   req, req_addr  - per-requester request and address
//                    (requester i uses slice [i*ADDR_W +: ADDR_W])
//   gnt            - one-hot grant; an event moves when req[i] and gnt[i] are both high
//   hold           - core is in its spike/store phase; dispatch is paused
//   out_valid      - the FIFO head is presented to the core
//   out_addr       - the FIFO head address (0 when the FIFO is empty)
//   out_ready      - the core takes the presented event
//   count, full    - FIFO occupancy, and the flag for occupancy == DEPTH
module event_scheduler
    import snn_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int ADDR_W  = ADDR_W_DEF,
    parameter  int DEPTH   = DEPTH_DEF,
    localparam int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        gnt,
    input  logic                      hold,
    output logic                      out_valid,
    output logic [ADDR_W-1:0]         out_addr,
    input  logic                      out_ready,
    output logic [CNT_W-1:0]          count,
    output logic                      full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = idx_width(NUM_REQ);

    logic [IDX_W-1:0]  rr_ptr_q,  rr_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [ADDR_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  gnt_idx;
    logic              gnt_valid;
    logic [ADDR_W-1:0] push_addr;
    logic              push;
    logic              pop;

    assign full = (count_q == CNT_W'(DEPTH));

    // Full blocks grants outright, even when a pop happens in the same
    // cycle. Because of this a push can never land in a slot that is still occupied.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .enable    (!full && !reset),
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_comb begin
        push_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                push_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // The arbiter only grants a requesting index, so a grant is a transfer.
    assign push      = gnt_valid;
    assign out_valid = (count_q != '0) && !hold;
    assign out_addr  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (push) begin
            rr_ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
        end
        // DEPTH is a power of two, so the pointers wrap by natural overflow.
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset. Clearing count_q hides any stale entries.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_addr;
        end
    end

endmodule

// File: tb/tb_event_scheduler.sv
module tb_event_scheduler;
    import snn_pkg::*;

    localparam int NR  = 4;
    localparam int AW  = 4;
    localparam int DP  = 8;
    localparam int CW  = $clog2(DP) + 1;
    localparam int RAW = NR * AW;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [NR-1:0]  req = '0;
    logic [RAW-1:0] req_addr = '0;
    logic           hold = 1'b0;
    logic           out_ready = 1'b0;
    logic [NR-1:0]  gnt;
    logic           out_valid;
    logic [AW-1:0]  out_addr;
    logic [CW-1:0]  count;
    logic           full;

    int checks = 0;
    int failures = 0;

    event_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .hold      (hold),
        .out_valid (out_valid),
        .out_addr  (out_addr),
        .out_ready (out_ready),
        .count     (count),
        .full      (full)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a queue of addresses and a round-robin start index.
    evt_addr_t mq[$];
    int        rr_m = 0;

    always @(negedge clock) begin
        logic [NR-1:0] eg;
        int            eidx;
        int            cand;
        logic          ev;
        logic [AW-1:0] ea;
        if (reset) begin
            mq.delete();
            rr_m = 0;
            chk("m_rst_gnt", 32'(gnt), 32'd0);
            chk("m_rst_valid", 32'(out_valid), 32'd0);
            chk("m_rst_addr", 32'(out_addr), 32'd0);
            chk("m_rst_count", 32'(count), 32'd0);
            chk("m_rst_full", 32'(full), 32'd0);
        end else begin
            eg   = '0;
            eidx = -1;
            if (mq.size() < DP) begin
                for (int k = 0; k < NR; k++) begin
                    cand = (rr_m + k) % NR;
                    if (eidx < 0 && req[cand]) eidx = cand;
                end
            end
            if (eidx >= 0) eg[eidx] = 1'b1;
            ev = (mq.size() > 0) && !hold;
            ea = (mq.size() > 0) ? mq[0] : '0;
            chk("m_gnt", 32'(gnt), 32'(eg));
            chk("m_valid", 32'(out_valid), 32'(ev));
            chk("m_addr", 32'(out_addr), 32'(ea));
            chk("m_count", 32'(count), 32'(mq.size()));
            chk("m_full", 32'(full), 32'(mq.size() == DP));
            if (ev && out_ready) void'(mq.pop_front());
            if (eidx >= 0) begin
                mq.push_back(req_addr[eidx*AW +: AW]);
                rr_m = (eidx + 1) % NR;
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        req = '0;
        hold = 1'b0;
        out_ready = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    int exp_g[5] = '{1, 2, 4, 8, 1};
    int exp_a[5] = '{1, 2, 3, 4, 1};
    int ngr;

    initial begin
        // Reset state, with all requests high so the grant gating is exercised.
        req = 4'hF;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        req = '0;
        cyc();
        do_reset();

        // Single event from requester 2.
        req = 4'b0100;
        req_addr[8 +: 4] = 4'h5;
        out_ready = 1'b1;
        #1;
        chk("single_gnt", 32'(gnt), 32'h4);
        cyc();
        req = '0;
        #1;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_addr", 32'(out_addr), 32'h5);
        chk("single_count1", 32'(count), 32'd1);
        cyc();
        chk("single_count0", 32'(count), 32'd0);
        chk("single_valid0", 32'(out_valid), 32'd0);

        // Fairness across four continuous requesters.
        do_reset();
        req_addr = 16'h4321;
        req = 4'hF;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("fair_gnt", 32'(gnt), 32'(exp_g[k]));
            if (k > 0) chk("fair_addr", 32'(out_addr), 32'(exp_a[k-1]));
            cyc();
        end
        chk("fair_addr_last", 32'(out_addr), 32'(exp_a[4]));

        // Fill to full with no pops, then pop once.
        do_reset();
        req_addr = 16'h0007;
        req = 4'b0001;
        ngr = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (gnt[0]) ngr++;
            cyc();
        end
        #1;
        chk("full_grants", 32'(ngr), 32'd8);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd8);
        chk("full_gnt0", 32'(gnt), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("full_pop_gnt0", 32'(gnt), 32'd0);
        cyc();
        out_ready = 1'b0;
        #1;
        chk("full_count7", 32'(count), 32'd7);
        chk("full_regrant", 32'(gnt), 32'd1);
        cyc();
        chk("full_count8", 32'(count), 32'd8);

        // Hold blocks dispatch.
        do_reset();
        req = 4'b0010;
        for (int a = 10; a < 13; a++) begin
            req_addr[4 +: 4] = 4'(a);
            cyc();
        end
        req = '0;
        hold = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("hold_valid", 32'(out_valid), 32'd0);
            chk("hold_count", 32'(count), 32'd3);
            cyc();
        end
        hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("hold_rel_valid", 32'(out_valid), 32'd1);
            chk("hold_rel_addr", 32'(out_addr), 32'(10 + k));
            cyc();
        end
        chk("hold_drained", 32'(count), 32'd0);

        // Simultaneous push and pop at count 4.
        do_reset();
        req = 4'b0001;
        for (int a = 1; a < 5; a++) begin
            req_addr[0 +: 4] = 4'(a);
            cyc();
        end
        req_addr[0 +: 4] = 4'h5;
        out_ready = 1'b1;
        #1;
        chk("pp_head", 32'(out_addr), 32'd1);
        cyc();
        req = '0;
        #1;
        chk("pp_count", 32'(count), 32'd4);
        for (int k = 2; k < 6; k++) begin
            #1;
            chk("pp_order", 32'(out_addr), 32'(k));
            cyc();
        end
        chk("pp_empty", 32'(count), 32'd0);

        // Reset mid-stream with five events queued.
        do_reset();
        req = 4'b0001;
        req_addr = 16'h0009;
        for (int k = 0; k < 5; k++) cyc();
        req = '0;
        #1;
        chk("mid_count5", 32'(count), 32'd5);
        reset = 1'b1;
        #1;
        chk("mid_async_count", 32'(count), 32'd0);
        chk("mid_async_valid", 32'(out_valid), 32'd0);
        cyc();
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("mid_post_valid", 32'(out_valid), 32'd0);
            cyc();
        end

        // Randomized traffic checked by the model every cycle.
        for (int n = 0; n < 2000; n++) begin
            req       = NR'($urandom);
            req_addr  = RAW'($urandom);
            hold      = ($urandom_range(0, 3) == 0);
            out_ready = (n % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 199) == 0);
            cyc();
        end
        reset = 1'b0;
        req = '0;
        cyc();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
